// File: rtl/fp_trig_seq.sv
// fp_trig_seq: sequencer for the combinational fp64 sine/cosine datapath.
// Accepts FSIN/FCOS/FSINCOS requests and presents the operand to the datapath.
// After a fixed settle window it captures the results and returns them as
// response beats: one beat for FSIN/FCOS, two for FSINCOS (sine first).
// Operands with |x| >= 2^63 bypass the datapath and are returned with C2 set.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised it holds until that edge, and the payload
// stays bit-stable while valid && !ready. abort overrides any handshake in the
// same cycle, so a beat in its handshake cycle is treated as not delivered.
module fp_trig_seq #(
   parameter int WAIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [63:0] req_a,
   input  logic        abort,
   output logic [63:0] dp_a,
   input  logic [63:0] dp_sin,
   input  logic [63:0] dp_cos,
   input  logic        dp_invalid,
   input  logic        dp_inexact,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_last,
   output logic        rsp_invalid,
   output logic        rsp_inexact,
   output logic        rsp_c2,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SETTLE     = 2'd1,
      RESP_FIRST = 2'd2,
      RESP_LAST  = 2'd3
   } state_t;

   localparam logic [1:0] OP_FCOS    = 2'd1;
   localparam logic [1:0] OP_FSINCOS = 2'd2;

   // Counter starts at WAIT_CYCLES-1; capture happens on the edge where it reads 0.
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic [1:0]  op;
   logic [63:0] cap_cos;
   logic [10:0] a_exp;
   logic        out_of_range;
   logic        accept;

   // Biased exponent >= 1023+63 means |x| >= 2^63; NaN/Inf (0x7FF) still go to the datapath.
   assign a_exp        = req_a[62:52];
   assign out_of_range = (a_exp >= 11'h43E) && (a_exp != 11'h7FF);

   assign req_ready = (state == IDLE) && !abort;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP_FIRST) || (state == RESP_LAST);
   assign busy      = (state != IDLE);

   // Control FSM with registered operand, capture and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         op          <= 2'd0;
         dp_a        <= 64'd0;
         cap_cos     <= 64'd0;
         rsp_data    <= 64'd0;
         rsp_last    <= 1'b0;
         rsp_invalid <= 1'b0;
         rsp_inexact <= 1'b0;
         rsp_c2      <= 1'b0;
      end else if (abort) begin
         // Flush: drop any work in flight; dp_a keeps its last operand.
         state    <= IDLE;
         rsp_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (out_of_range) begin
                     state       <= RESP_LAST;
                     rsp_data    <= req_a;
                     rsp_last    <= 1'b1;
                     rsp_invalid <= 1'b0;
                     rsp_inexact <= 1'b0;
                     rsp_c2      <= 1'b1;
                  end else begin
                     state <= SETTLE;
                     dp_a  <= req_a;
                     cnt   <= CNT_LOAD;
                     op    <= req_op;
                  end
               end
            end
            SETTLE: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  cap_cos     <= dp_cos;
                  rsp_invalid <= dp_invalid;
                  rsp_inexact <= dp_inexact;
                  rsp_c2      <= 1'b0;
                  if (op == OP_FSINCOS) begin
                     state    <= RESP_FIRST;
                     rsp_data <= dp_sin;
                     rsp_last <= 1'b0;
                  end else if (op == OP_FCOS) begin
                     state    <= RESP_LAST;
                     rsp_data <= dp_cos;
                     rsp_last <= 1'b1;
                  end else begin
                     // FSIN and the reserved encoding both return the sine.
                     state    <= RESP_LAST;
                     rsp_data <= dp_sin;
                     rsp_last <= 1'b1;
                  end
               end
            end
            RESP_FIRST: begin
               if (rsp_ready) begin
                  state    <= RESP_LAST;
                  rsp_data <= cap_cos;
                  rsp_last <= 1'b1;
               end
            end
            RESP_LAST: begin
               if (rsp_ready) begin
                  state    <= IDLE;
                  rsp_last <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_trig_seq.sv
// tb_fp_trig_seq: directed bench for fp_trig_seq with a behavioural datapath,
// an expected-beat queue and a per-cycle response comparator.
module tb_fp_trig_seq;

   localparam int W = 4;

   localparam logic [63:0] PI_2  = 64'h3FF921FB54442D18;
   localparam logic [63:0] ONE   = 64'h3FF0000000000000;
   localparam logic [63:0] P_INF = 64'h7FF0000000000000;
   localparam logic [63:0] QNAN  = 64'h7FF8000000000000;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [63:0] req_a;
   logic        abort;
   logic [63:0] dp_a;
   logic [63:0] dp_sin;
   logic [63:0] dp_cos;
   logic        dp_invalid;
   logic        dp_inexact;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_last;
   logic        rsp_invalid;
   logic        rsp_inexact;
   logic        rsp_c2;
   logic        busy;

   // Expected beats: {data, last, invalid, inexact, c2}
   logic [67:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          beats    = 0;

   logic [63:0]  prev_a = 64'd0;
   int           age = 0;
   logic [129:0] dp_true;
   logic         settled;

   fp_trig_seq #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a),
      .abort(abort),
      .dp_a(dp_a), .dp_sin(dp_sin), .dp_cos(dp_cos),
      .dp_invalid(dp_invalid), .dp_inexact(dp_inexact),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .rsp_invalid(rsp_invalid), .rsp_inexact(rsp_inexact),
      .rsp_c2(rsp_c2), .busy(busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference sin/cos/flags for an operand: known points plus a bit-pattern rule elsewhere.
   function automatic logic [129:0] dp_fn(input logic [63:0] a);
      case (a)
         64'h0000000000000000: return {64'h0000000000000000, ONE, 1'b0, 1'b0};
         P_INF:                return {QNAN, QNAN, 1'b1, 1'b0};
         PI_2:                 return {ONE, 64'h3C91A62633145C07, 1'b0, 1'b1};
         default:              return {a ^ 64'h0F0F0F0F0F0F0F0F, a ^ 64'hF0F0F0F0F0F0F0F0, a[0], a[1]};
      endcase
   endfunction

   // Count how many negedges dp_a has been stable; results are only valid once settled.
   always @(negedge clk) begin
      if (dp_a !== prev_a) age <= 0;
      else if (age < 15) age <= age + 1;
      prev_a <= dp_a;
   end

   // Datapath model: garbage until the operand has settled, and again once a response is up,
   // so the sequencer must sample at exactly the right edge and serve beats from its own capture.
   always_comb begin
      dp_true    = dp_fn(dp_a);
      settled    = (age >= W - 1) && !rsp_valid;
      dp_sin     = settled ? dp_true[129:66] : 64'hDEADBEEF0BADF00D;
      dp_cos     = settled ? dp_true[65:2]   : 64'hBAADCAFE12345678;
      dp_invalid = settled ? dp_true[1] : ~dp_true[1];
      dp_inexact = settled ? dp_true[0] : ~dp_true[0];
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Expected beats for an accepted request, from the x87 rules.
   task automatic push_expected(input logic [1:0] op, input logic [63:0] a);
      logic [129:0] r;
      logic         huge;
      huge = (a[62:0] >= 63'h43E0000000000000) && (a[62:52] != 11'h7FF);
      r = dp_fn(a);
      if (huge) exp_q.push_back({a, 1'b1, 1'b0, 1'b0, 1'b1});
      else if (op == 2'd2) begin
         exp_q.push_back({r[129:66], 1'b0, r[1], r[0], 1'b0});
         exp_q.push_back({r[65:2],   1'b1, r[1], r[0], 1'b0});
      end else if (op == 2'd1) exp_q.push_back({r[65:2], 1'b1, r[1], r[0], 1'b0});
      else exp_q.push_back({r[129:66], 1'b1, r[1], r[0], 1'b0});
   endtask

   // Scoreboard: every valid cycle must match the head beat; handshake pops, abort flushes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: got %h last %b", rsp_data, rsp_last);
            end else if ({rsp_data, rsp_last, rsp_invalid, rsp_inexact, rsp_c2} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL beat: got %h/%b%b%b%b expected %h/%b", rsp_data, rsp_last,
                        rsp_invalid, rsp_inexact, rsp_c2, exp_q[0][67:4], exp_q[0][3:0]);
            end
            n_checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_ready_during_rsp: got busy %b ready %b expected 1 0", busy, req_ready);
            end
            if (rsp_ready && !abort && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               beats++;
            end
         end
         if (abort) exp_q.delete();
      end
   end

   // Driver: wait for ready (bounded), present one request for one edge.
   task automatic issue(input logic [1:0] op, input logic [63:0] a);
      int t = 0;
      while (!req_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!req_ready) chk("issue_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_op = op; req_a = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
      push_expected(op, a);
   endtask

   // Count edges after the accept edge until rsp_valid is seen.
   task automatic wait_valid(output int n);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (!rsp_valid) chk("valid_timeout", 64'(rsp_valid), 64'd1);
   endtask

   task automatic drain();
      int t = 0;
      rsp_ready = 1'b1;
      while (busy && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (busy) chk("drain_timeout", 64'(busy), 64'd0);
   endtask

   task automatic idle_no_valid(input string name, input int cycles);
      int v = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) v++;
      end
      chk(name, 64'(v), 64'd0);
   endtask

   initial begin
      int n;
      int h0;
      rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 64'd0;
      abort = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_dp_a", dp_a, 64'd0);
      chk("reset_rsp_data", rsp_data, 64'd0);
      chk("reset_rsp_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'd0);
      @(posedge clk); #1;

      // FSINCOS of +0
      issue(2'd2, 64'd0);
      wait_valid(n);
      chk("sincos_latency", 64'(n), 64'(W));
      chk("sincos_beat0_data", rsp_data, 64'd0);
      chk("sincos_beat0_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'b0000);
      @(posedge clk); #1;
      chk("sincos_beat1_data", rsp_data, ONE);
      chk("sincos_beat1_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'b1000);
      @(posedge clk); #1;
      chk("sincos_done_valid", 64'(rsp_valid), 64'd0);
      chk("sincos_done_ready", 64'(req_ready), 64'd1);

      // FCOS of +Inf
      issue(2'd1, P_INF);
      wait_valid(n);
      chk("fcos_inf_latency", 64'(n), 64'(W));
      chk("fcos_inf_data", rsp_data, QNAN);
      chk("fcos_inf_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'b1100);
      drain();

      // FSIN of 2^63: out of range
      issue(2'd0, 64'h43E0000000000000);
      wait_valid(n);
      chk("oor_latency", 64'(n), 64'd0);
      chk("oor_data", rsp_data, 64'h43E0000000000000);
      chk("oor_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'b1001);
      chk("oor_dp_a_kept", dp_a, P_INF);
      drain();

      // FSIN of pi/2 with backpressure
      rsp_ready = 1'b0;
      issue(2'd0, PI_2);
      wait_valid(n);
      h0 = beats;
      for (int i = 0; i < 5; i++) begin
         chk("stall_data", rsp_data, ONE);
         chk("stall_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'b1010);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_done_valid", 64'(rsp_valid), 64'd0);
      chk("stall_done_busy", 64'(busy), 64'd0);
      chk("stall_done_ready", 64'(req_ready), 64'd1);
      chk("stall_one_handshake", 64'(beats - h0), 64'd1);

      // Boundaries: just below 2^63, -2^63 as FSINCOS, NaN operand
      issue(2'd3, 64'h43DFFFFFFFFFFFFF);
      wait_valid(n);
      chk("below_2p63_latency", 64'(n), 64'(W));
      chk("reserved_op_last", 64'(rsp_last), 64'd1);
      drain();
      issue(2'd2, 64'hC3E0000000000000);
      wait_valid(n);
      chk("neg_oor_latency", 64'(n), 64'd0);
      chk("neg_oor_single_beat", 64'({rsp_last, rsp_c2}), 64'b11);
      drain();
      issue(2'd2, 64'h7FF8000000000001);
      wait_valid(n);
      chk("nan_latency", 64'(n), 64'(W));
      drain();

      // Abort during SETTLE
      issue(2'd2, 64'h3FE0000000000003);
      @(posedge clk); #1;
      abort = 1'b1;
      #1 chk("abort_blocks_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_settle_busy", 64'(busy), 64'd0);
      idle_no_valid("abort_settle_no_valid", 8);
      issue(2'd1, 64'd0);
      wait_valid(n);
      chk("after_abort1_data", rsp_data, ONE);
      drain();

      // Abort together with a request in IDLE: no accept
      req_valid = 1'b1; req_op = 2'd0; req_a = 64'h3FE0000000000000; abort = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; abort = 1'b0;
      chk("abort_vs_req_busy", 64'(busy), 64'd0);
      chk("abort_vs_req_dp_a", dp_a, 64'd0);

      // Abort during RESP_FIRST handshake cycle
      issue(2'd2, 64'h3FE0000000000003);
      wait_valid(n);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_resp_valid", 64'(rsp_valid), 64'd0);
      chk("abort_resp_busy", 64'(busy), 64'd0);
      idle_no_valid("abort_resp_no_valid", 6);
      issue(2'd1, 64'd0);
      wait_valid(n);
      chk("after_abort2_data", rsp_data, ONE);
      drain();

      // Asynchronous reset in RESP_FIRST
      rsp_ready = 1'b0;
      issue(2'd2, 64'h3FE0000000000003);
      wait_valid(n);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(rsp_valid), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_data", rsp_data, 64'd0);
      chk("async_rst_flags", 64'({rsp_last, rsp_invalid, rsp_inexact, rsp_c2}), 64'd0);
      chk("async_rst_dp_a", dp_a, 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1 chk("post_rst_ready", 64'(req_ready), 64'd1);

      repeat (3) @(posedge clk);
      #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_trig_seq.md
Name: fp_trig_seq

Overview:
- Sequencer/controller for the combinational fp64 sine/cosine datapath inside the ao486 FPU.
- Accepts FSIN/FCOS/FSINCOS requests from the FPU microcode with a valid/ready handshake, and drives the operand into the datapath.
- Holds the operand stable for a programmable multicycle settle window, then captures the results and flags. Returns them as one response beat, or two for FSINCOS.
- Performs x87 out-of-range detection (|x| >= 2^63 sets C2, operand returned unchanged), so the datapath never sees those operands as live work.

Parameters:
- WAIT_CYCLES, 4, number of clock edges the datapath is allowed to settle after the operand is registered; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  0=FSIN, 1=FCOS, 2=FSINCOS, 3=reserved (treated as FSIN)
- req_a  in  64  IEEE-754 double operand
- abort  in  1  FPU flush; kills any operation in flight
- dp_a  out  64  operand to the sin/cos datapath (registered)
- dp_sin  in  64  datapath sine result
- dp_cos  in  64  datapath cosine result
- dp_invalid  in  1  datapath invalid flag
- dp_inexact  in  1  datapath inexact flag
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  consumer accepts the beat
- rsp_data  out  64  result value
- rsp_last  out  1  final beat of this operation
- rsp_invalid  out  1  IE flag for this operation
- rsp_inexact  out  1  PE flag for this operation
- rsp_c2  out  1  x87 C2 (operand out of range)
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE; dp_a=0.
  - rsp_valid=0, rsp_data=0, rsp_last=0, rsp_invalid=0, rsp_inexact=0, rsp_c2=0.
  - busy=0; internal sin/cos/flag capture registers=0; counter=0.
  - req_ready=1 after reset unless abort is asserted.
- req_ready = (state==IDLE) && !abort. A request is accepted on a rising edge with req_valid && req_ready.
- Out-of-range test on req_a:
  - Out of range when exponent field >= 1023+63 (0x43E) and exponent != 0x7FF.
  - NaN and Inf are not out of range; they go to the datapath.
- States and transitions:
  - IDLE:
    - Accept of an out-of-range operand -> RESP_LAST, with rsp_data=req_a, rsp_c2=1, invalid=0, inexact=0, rsp_last=1. This is a single beat even for FSINCOS. dp_a is not updated.
    - Any other accept -> SETTLE: dp_a<=req_a, counter<=WAIT_CYCLES-1, latch the op.
  - SETTLE:
    - Counter != 0: decrement.
    - Counter == 0: capture dp_sin, dp_cos, dp_invalid, dp_inexact. Set rsp_c2=0.
      - FSINCOS -> RESP_FIRST with rsp_data=sin, rsp_last=0.
      - FSIN -> RESP_LAST with rsp_data=sin, rsp_last=1.
      - FCOS -> RESP_LAST with rsp_data=cos, rsp_last=1.
  - RESP_FIRST:
    - rsp_valid=1.
    - On rsp_ready: go to RESP_LAST with rsp_data=captured cos, rsp_last=1. Flags are unchanged (the same on both beats).
  - RESP_LAST:
    - rsp_valid=1.
    - On rsp_ready: go to IDLE. rsp_valid=0 and rsp_last=0 from the next cycle.
- Latency:
  - In-range: the first rsp_valid is high in the cycle after edge N+WAIT_CYCLES, where N is the accept edge.
  - Out-of-range: rsp_valid is high the cycle after the accept edge.
- Backpressure: while rsp_valid && !rsp_ready, the values of rsp_data, rsp_last and all flags are held bit-stable.
- dp_a is held stable from its load until the next in-range accept; it is not cleared on response completion.
- A new request cannot be accepted in the same cycle as the final beat's handshake; req_ready rises the cycle after the return to IDLE. No bubble-free back-to-back issue.
- Abort:
  - Synchronous. Any state goes to IDLE on the next edge; rsp_valid=0 from that edge. Captured data is discarded.
  - Abort during a response handshake cycle: the beat is considered not delivered.
  - Abort and req_valid in the same cycle: abort wins; no accept.
  - dp_a is not cleared by abort.
- Reset mid-operation: immediate return to reset values, independent of the clock.
- busy=1 in SETTLE, RESP_FIRST and RESP_LAST.

Test Plan:
- WAIT_CYCLES=4, FSINCOS, req_a=0x0000000000000000:
  - Beat0 rsp_data=0x0000000000000000, last=0.
  - Beat1 rsp_data=0x3FF0000000000000, last=1.
  - invalid=0, inexact=0, c2=0.
  - Beat0 rsp_valid first high 4 edges after accept.
- FCOS, req_a=0x7FF0000000000000 (+Inf) -> single beat rsp_data=0x7FF8000000000000, invalid=1, c2=0, last=1.
- FSIN, req_a=0x43E0000000000000 (2^63):
  - Single beat rsp_data=0x43E0000000000000, c2=1, invalid=0, inexact=0.
  - rsp_valid high one cycle after accept; dp_a unchanged from the prior value.
- FSIN, req_a=0x3FF921FB54442D18 (pi/2), rsp_ready held low 5 cycles:
  - rsp_data equals dp_sin as sampled at capture, stable across all stall cycles.
  - Exactly one handshake, then busy=0 and req_ready=1 the next cycle.
- FSINCOS with abort pulsed during SETTLE (and again during RESP_FIRST in a second run):
  - No further rsp_valid; state IDLE next edge.
  - A subsequent FCOS of 0x0 returns 0x3FF0000000000000 normally.
- rst_n asserted asynchronously mid-RESP_FIRST -> rsp_valid, busy and all response outputs 0 without a clock edge; req_ready=1 after reset release.
